// File: rtl/seq_capture_ctrl_pkg.sv
// Shared definitions for the wait-then-capture sequencer: FSM state encoding
// and the width helpers used to size the channel index.
package seq_capture_ctrl_pkg;

  // Sequencer states; encodings are fixed so they read the same in any dump.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Channel index width; a single channel still needs one bit of ch_sel.
  function automatic int chWidth(input int nch);
    int w;
    w = clog2(nch);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_capture_ctrl_if.sv
// Bundle of the sequencer control inputs and capture outputs. The master side
// (RTC read mux / display logic) requests sequences and supplies data; the
// slave side is the sequencer itself.
interface seq_capture_if
  import seq_capture_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4,
  parameter int NCH    = 3
) ();

  localparam int CH_W = chWidth(NCH);

  logic                    start;
  logic                    abort;
  logic                    cont;
  logic [CNT_W-1:0]        wait_cyc;
  logic [DATA_W-1:0]       dato_in;
  logic [CH_W-1:0]         ch_sel;
  logic                    cap_stb;
  logic                    busy;
  logic                    done;
  logic [NCH*DATA_W-1:0]   dato_out;

  modport master (
    output start,
    output abort,
    output cont,
    output wait_cyc,
    output dato_in,
    input  ch_sel,
    input  cap_stb,
    input  busy,
    input  done,
    input  dato_out
  );

  modport slave (
    input  start,
    input  abort,
    input  cont,
    input  wait_cyc,
    input  dato_in,
    output ch_sel,
    output cap_stb,
    output busy,
    output done,
    output dato_out
  );

endinterface

// File: rtl/seq_capture_ctrl_wait_timer.sv
// Per-channel wait counter. Holds the wait count sampled at sequence start and
// counts clocks since the channel was selected; hit marks the capture clock.
module seq_wait_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_wait_cyc,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_wait_q;

  // Load takes a fresh wait count and restarts; clear restarts; inc advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_wait_q <= '0;
    end else if (i_load) begin
      r_wait_q <= i_wait_cyc;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The counter is cleared on hit, so it never passes r_wait_q and never wraps.
  assign o_hit = (r_cnt == r_wait_q);

endmodule

// File: rtl/seq_capture_ctrl.sv
// Programmable wait-then-capture sequencer. Steps ch_sel through NCH channels,
// waits wait_cyc+1 clocks on each, latches dato_in into that channel's slot and
// pulses done after the last one. Optionally restarts straight from DONE.
module seq_capture_ctrl
  import seq_capture_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4,
  parameter int NCH    = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_capture_if.slave bus
);

  localparam int              CH_W    = chWidth(NCH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  state_t                r_state;
  logic [CH_W-1:0]       r_ch_sel;
  logic                  r_cap_stb;
  logic                  r_busy;
  logic                  r_done;
  logic [NCH*DATA_W-1:0] r_dato_out;

  logic w_load;
  logic w_clear;
  logic w_inc;
  logic w_hit;

  // Timer control: reload on start accept or continuous restart, clear on
  // capture or abort, otherwise keep counting while waiting.
  always_comb begin
    w_load  = 1'b0;
    w_clear = 1'b0;
    w_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load = bus.start;
      end
      S_WAIT: begin
        if (bus.abort || w_hit) begin
          w_clear = 1'b1;
        end else begin
          w_inc = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.abort) begin
          w_clear = 1'b1;
        end else if (bus.cont) begin
          w_load = 1'b1;
        end
      end
      default: begin
        w_clear = 1'b1;
      end
    endcase
  end

  seq_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_clear    (w_clear),
    .i_inc      (w_inc),
    .i_wait_cyc (bus.wait_cyc),
    .o_hit      (w_hit)
  );

  // Sequencer FSM with registered strobes; abort outranks a same-edge capture
  // so a cancelled channel never overwrites its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ch_sel   <= '0;
      r_cap_stb  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dato_out <= '0;
    end else begin
      r_cap_stb <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ch_sel <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.abort) begin
            r_ch_sel <= '0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_hit) begin
            for (int i = 0; i < NCH; i++) begin
              if (r_ch_sel == CH_W'(i)) begin
                r_dato_out[i*DATA_W +: DATA_W] <= bus.dato_in;
              end
            end
            r_cap_stb <= 1'b1;
            if (r_ch_sel == LAST_CH) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_ch_sel <= r_ch_sel + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_ch_sel <= '0;
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (bus.cont) begin
            r_state <= S_WAIT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ch_sel <= '0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ch_sel   = r_ch_sel;
  assign bus.cap_stb  = r_cap_stb;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.dato_out = r_dato_out;

endmodule
